mem_seq_master: RTL and testbench
=================================

MEM_SEQ_MASTER -- requirements
Module: mem_seq_master

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; multiple of 8, minimum 8.
REQ-002 Parameter ADDR_W, default 32, Avalon byte-address width.
REQ-003 Parameter LEN_W, default 8, width of the transfer-length field; maximum run is 2^LEN_W-1 words.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 go  in  1  command strobe; sampled only while ready=1.
REQ-007 rd_nwr  in  1  command mode: 1=read run, 0=write run; sampled with go.
REQ-008 addr  in  ADDR_W  start byte address; sampled with go.
REQ-009 len  in  LEN_W  number of words in the run; sampled with go.
REQ-010 ready  out  1  high when idle and able to accept go.
REQ-011 done  out  1  one-cycle pulse when a run completes.
REQ-012 wr_data  in  DATA_W  write-stream word.
REQ-013 wr_valid  in  1  wr_data is valid.
REQ-014 wr_ready  out  1  block accepts wr_data this cycle; transfer occurs when wr_valid and wr_ready are both 1.
REQ-015 rd_data  out  DATA_W  read-stream word.
REQ-016 rd_valid  out  1  one-cycle qualifier for rd_data; no backpressure.
REQ-017 address  out  ADDR_W  Avalon address.
REQ-018 write  out  1  Avalon write request.
REQ-019 writedata  out  DATA_W  Avalon write data.
REQ-020 read  out  1  Avalon read request.
REQ-021 readdata  in  DATA_W  Avalon read data.
REQ-022 readdatavalid  in  1  Avalon read data qualifier.
REQ-023 waitrequest  in  1  Avalon slave stall.

Function
REQ-024 The state machine SHALL have the states IDLE, WR_FETCH, WR_ISSUE, RD_ISSUE, RD_WAIT and DONE.
REQ-025 IDLE: ready=1; go with len=0 -> DONE; go with len>0 -> capture addr to address, len to the remaining-word counter, then WR_FETCH if rd_nwr=0 or RD_ISSUE if rd_nwr=1.
REQ-026 ready SHALL be 0 in every state except IDLE; go outside IDLE is ignored.
REQ-027 WR_FETCH: wr_ready=1, write=0; on wr_valid -> writedata<=wr_data, write<=1, WR_ISSUE.
REQ-028 wr_ready SHALL be 0 in every state except WR_FETCH.
REQ-029 WR_ISSUE: hold write=1 with address and writedata stable while waitrequest=1.
REQ-030 WR_ISSUE with waitrequest=0: write<=0, decrement counter; counter was 1 -> DONE; otherwise address+=DATA_W/8 and WR_FETCH.
REQ-031 RD_ISSUE: hold read=1 with address stable while waitrequest=1; on waitrequest=0 -> read<=0, RD_WAIT.
REQ-032 RD_WAIT: on readdatavalid -> rd_data<=readdata and rd_valid=1 for exactly one cycle, decrement counter; counter was 1 -> DONE; otherwise address+=DATA_W/8 and RD_ISSUE.
REQ-033 At most one Avalon read SHALL be outstanding; readdatavalid outside RD_WAIT is ignored.
REQ-034 read and write SHALL never be 1 in the same cycle.
REQ-035 DONE: done=1 for one cycle, then IDLE; ready=1 on the cycle after done.
REQ-036 Address arithmetic SHALL be modulo 2^ADDR_W; an increment from the top address wraps to 0 with no error.
REQ-037 Minimum cost per word: 2 cycles for a write with waitrequest=0 and wr_valid held high; 2 cycles plus read latency for a read.

Reset
REQ-038 While resetn=0, asynchronously: state=IDLE; address, writedata, rd_data and the counter are 0; write, read, rd_valid, wr_ready and done are 0.
REQ-039 ready SHALL be 0 during reset and 1 from the first clock edge after resetn deasserts.
REQ-040 Reset mid-run SHALL abort the run immediately, with no done pulse; a read response arriving after reset is ignored.

Verification
REQ-041 DATA_W=32: go, rd_nwr=0, addr=0x100, len=3, wr_data 0xA,0xB,0xC, waitrequest=0 -> writes 0xA@0x100, 0xB@0x104, 0xC@0x108, then one done pulse.
REQ-042 Write run len=1 with waitrequest high for 4 cycles -> write, address and writedata held for 5 cycles, then done.
REQ-043 Read run addr=0x40, len=2, slave returns 0x11 and 0x22 after 3-cycle latency -> reads at 0x40 and 0x44; rd_valid pulses carry 0x11 and 0x22; then done.
REQ-044 go with len=0 -> no read or write; done on the 2nd edge after go; ready=1 on the next cycle.
REQ-045 ADDR_W=16, addr=0xFFFC, len=2, write run -> second write at address 0x0000.
REQ-046 resetn pulled low in WR_ISSUE -> write=0 and ready=0 asynchronously; no done; ready=1 one edge after release.

Source files
------------

// File: rtl/mem_seq_master.sv
// Sequential Avalon-MM master: moves a run of len words between a valid/ready
// word stream and an Avalon slave, one transfer at a time, starting at addr.
module mem_seq_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    // command port: go is taken only in a cycle where ready=1
    input  logic              go,
    input  logic              rd_nwr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              ready,
    output logic              done,
    // write stream: a word moves on a cycle with wr_valid=1 and wr_ready=1
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    // read stream: rd_valid is a single-cycle strobe, no backpressure
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    // Avalon-MM master
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              read,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    input  logic              waitrequest,
    // state observation
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_FETCH = 3'd1,
        S_WR_ISSUE = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    state_t              r_state;
    state_t              w_next;
    logic                r_armed;
    logic [LEN_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_writedata;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                w_accept;
    logic                w_last;

    assign w_accept  = go && ready;
    assign w_last    = (r_count == LEN_W'(1));
    assign address   = r_address;
    assign writedata = r_writedata;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_armed keeps ready low until the first edge after reset release.
    always_comb begin
        w_next   = r_state;
        ready    = 1'b0;
        wr_ready = 1'b0;
        write    = 1'b0;
        read     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = r_armed;
                if (go && r_armed) begin
                    if (len == '0) begin
                        w_next = S_DONE;
                    end else if (rd_nwr) begin
                        w_next = S_RD_ISSUE;
                    end else begin
                        w_next = S_WR_FETCH;
                    end
                end
            end
            S_WR_FETCH: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_next = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                write = 1'b1;
                if (!waitrequest) begin
                    w_next = w_last ? S_DONE : S_WR_FETCH;
                end
            end
            S_RD_ISSUE: begin
                read = 1'b1;
                if (!waitrequest) begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (readdatavalid) begin
                    w_next = w_last ? S_DONE : S_RD_ISSUE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_armed     <= 1'b0;
            r_count     <= '0;
            r_address   <= '0;
            r_writedata <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_armed    <= 1'b1;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (len != '0)) begin
                        r_address <= addr;
                        r_count   <= len;
                    end
                end
                S_WR_FETCH: begin
                    if (wr_valid) begin
                        r_writedata <= wr_data;
                    end
                end
                S_WR_ISSUE: begin
                    if (!waitrequest) begin
                        r_count <= r_count - LEN_W'(1);
                        if (!w_last) begin
                            r_address <= r_address + ADDR_STEP;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // Responses are only honoured here, so a stray or late one is dropped.
                    if (readdatavalid) begin
                        r_rd_data  <= readdata;
                        r_rd_valid <= 1'b1;
                        r_count    <= r_count - LEN_W'(1);
                        if (!w_last) begin
                            r_address <= r_address + ADDR_STEP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_master.sv
// Bench for mem_seq_master: Avalon slave model, expected-transfer scoreboard
// checked every cycle, and directed runs with hand-computed expectations.
module tb_mem_seq_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 8;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xfer_t;

    logic          clk;
    logic          resetn;
    logic          go;
    logic          rd_nwr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          ready;
    logic          done;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] address;
    logic          write;
    logic [DW-1:0] writedata;
    logic          read;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic [2:0]    dbg_state;

    mem_seq_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn), .go(go), .rd_nwr(rd_nwr), .addr(addr), .len(len),
        .ready(ready), .done(done), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .address(address), .write(write), .writedata(writedata), .read(read),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    xfer_t         exp_q[$];
    logic [DW-1:0] exp_rd_q[$];
    int            exp_done = 0;
    bit            chk_en = 0;
    bit            busy = 0;
    int            hold_cnt = 0;
    int            last_hold = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input int i);
        return AW'((int'(base) + i * (DW / 8)) % (1 << AW));
    endfunction

    // ---------------- Avalon slave model ----------------
    int            wait_cfg = 0;
    int            lat_cfg = 1;
    int            w_cnt = 0;
    int            rd_cnt = 0;
    bit            rd_pend = 0;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] mem [int];

    always @(posedge clk) begin
        #1;
        readdatavalid = 1'b0;
        readdata      = '0;
        if (!resetn) begin
            rd_pend     = 0;
            w_cnt       = 0;
            waitrequest = 1'b0;
        end else begin
            if (rd_pend) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    readdatavalid = 1'b1;
                    readdata      = mem.exists(int'(rd_addr_q)) ? mem[int'(rd_addr_q)] : 32'hDEAD_BEEF;
                    rd_pend       = 0;
                end
            end
            if (write || read) begin
                if (w_cnt < wait_cfg) begin
                    waitrequest = 1'b1;
                    w_cnt++;
                end else begin
                    waitrequest = 1'b0;
                    w_cnt = 0;
                    if (read) begin
                        rd_pend   = 1;
                        rd_cnt    = lat_cfg;
                        rd_addr_q = address;
                    end
                end
            end else begin
                waitrequest = 1'b0;
                w_cnt = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            xfer_t e;
            logic [DW-1:0] ed;
            check("rw_exclusive", read && write, 0);
            check("ready_vs_busy", ready, !busy);
            if ((write || read) && prev_stall) begin
                check("stall_addr_stable", address, prev_addr);
                if (write) check("stall_wdata_stable", writedata, prev_wd);
            end
            if (write) hold_cnt++;
            if ((write || read) && !waitrequest) begin
                check("xfer_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("xfer_kind", write, e.is_wr);
                    check("xfer_addr", address, e.addr);
                    if (write) check("xfer_wdata", writedata, e.data);
                end
                if (write) begin
                    last_hold = hold_cnt;
                    hold_cnt  = 0;
                end
            end
            prev_stall = (write || read) && waitrequest;
            prev_addr  = address;
            prev_wd    = writedata;
            if (rd_valid) begin
                check("rd_expected", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) begin
                    ed = exp_rd_q.pop_front();
                    check("rd_data", rd_data, ed);
                end
            end
            if (done) begin
                check("done_expected", exp_done > 0, 1);
                if (exp_done > 0) exp_done--;
                busy = 0;
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic issue_go(input bit rdn, input logic [AW-1:0] a, input logic [LW-1:0] n);
        int k = 0;
        while (!ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("ready_for_go", ready, 1);
        go = 1'b1; rd_nwr = rdn; addr = a; len = n;
        exp_done++;
        @(posedge clk); #1;
        go = 1'b0;
        busy = 1;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (exp_done > 0 && k < limit) begin
            @(posedge clk); #1; k++;
        end
        check("done_seen", exp_done, 0);
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0,
                               input logic [DW-1:0] step);
        issue_go(1'b0, a, LW'(n));
        for (int i = 0; i < n; i++) begin
            bit acc = 0;
            int k = 0;
            wr_valid = 1'b1;
            wr_data  = d0 + DW'(i) * step;
            while (!acc && k < 200) begin
                @(negedge clk); acc = wr_ready;
                @(posedge clk); #1; k++;
            end
            check("wr_word_accepted", acc, 1);
        end
        wr_valid = 1'b0;
        wait_done(200);
    endtask

    task automatic model_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0,
                               input logic [DW-1:0] step);
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, word_addr(a, i), d0 + DW'(i) * step});
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input int n, input bit poke_go);
        issue_go(1'b1, a, LW'(n));
        if (poke_go) begin
            go = 1'b1; rd_nwr = 1'b0; len = 1;
            @(posedge clk); #1;
            go = 1'b0;
        end
        wait_done(400);
    endtask

    task automatic model_read(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            mem[int'(word_addr(a, i))] = $urandom;
            exp_q.push_back('{1'b0, word_addr(a, i), '0});
            exp_rd_q.push_back(mem[int'(word_addr(a, i))]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        go = 0; rd_nwr = 0; addr = '0; len = '0; wr_data = '0; wr_valid = 0;
        readdata = '0; readdatavalid = 0; waitrequest = 0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_address", address, 0);
        check("rst_writedata", writedata, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", ready, 0);
        @(posedge clk); #1;
        check("ready_after_first_edge", ready, 1);
        chk_en = 1;

        // Three-word write, no stalls.
        exp_q.push_back('{1'b1, 16'h0100, 32'h0000_000A});
        exp_q.push_back('{1'b1, 16'h0104, 32'h0000_000B});
        exp_q.push_back('{1'b1, 16'h0108, 32'h0000_000C});
        drive_write(16'h0100, 3, 32'hA, 32'h1);

        // Single write stalled four cycles.
        wait_cfg = 4;
        exp_q.push_back('{1'b1, 16'h0200, 32'h5A5A_0001});
        drive_write(16'h0200, 1, 32'h5A5A_0001, 32'h0);
        check("wr_hold_cycles", last_hold, 5);
        wait_cfg = 0;

        // Two-word read, latency 3, with an ignored go mid-run.
        lat_cfg = 3;
        mem[16'h0040] = 32'h11;
        mem[16'h0044] = 32'h22;
        exp_q.push_back('{1'b0, 16'h0040, 32'h0});
        exp_q.push_back('{1'b0, 16'h0044, 32'h0});
        exp_rd_q.push_back(32'h11);
        exp_rd_q.push_back(32'h22);
        drive_read(16'h0040, 2, 1'b1);

        // Zero-length run: done after the second edge, ready on the next cycle.
        issue_go(1'b0, 16'h0700, '0);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_no_req", read || write, 0);
        @(posedge clk); #1;
        check("len0_done_cleared", done, 0);
        check("len0_ready_back", ready, 1);

        // Address wrap at the top of a 16-bit space.
        exp_q.push_back('{1'b1, 16'hFFFC, 32'hC0DE_0000});
        exp_q.push_back('{1'b1, 16'h0000, 32'hC0DE_0001});
        drive_write(16'hFFFC, 2, 32'hC0DE_0000, 32'h1);

        // Model-driven runs with stalls and latency.
        wait_cfg = 1;
        begin
            logic [DW-1:0] d0 = $urandom;
            logic [DW-1:0] st = $urandom;
            model_write(16'h0300, 5, d0, st);
            drive_write(16'h0300, 5, d0, st);
        end
        wait_cfg = 2; lat_cfg = 2;
        model_read(16'hFFF8, 4);
        drive_read(16'hFFF8, 4, 1'b0);
        wait_cfg = 0; lat_cfg = 1;
        model_read(16'h0800, 3);
        drive_read(16'h0800, 3, 1'b0);

        // Reset while a write is stalled.
        wait_cfg = 10;
        issue_go(1'b0, 16'h0500, 2);
        wr_valid = 1'b1; wr_data = 32'hBAD0_0000;
        begin
            int k = 0;
            while (!write && k < 20) begin
                @(posedge clk); #1; k++;
            end
            check("reach_wr_issue", write, 1);
        end
        wr_valid = 1'b0;
        @(negedge clk); #2;
        chk_en = 0;
        resetn = 1'b0;
        #1;
        check("midrun_rst_write", write, 0);
        check("midrun_rst_ready", ready, 0);
        check("midrun_rst_done", done, 0);
        exp_q.delete(); exp_rd_q.delete();
        exp_done = 0; busy = 0; wait_cfg = 0;
        prev_stall = 0; hold_cnt = 0;
        @(posedge clk); #1;
        check("midrun_rst_no_done", done, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("midrun_ready_before_edge", ready, 0);
        check("midrun_no_done_after", done, 0);
        @(posedge clk); #1;
        check("midrun_ready_after_edge", ready, 1);
        chk_en = 1;

        // Recovery run after the abort.
        model_write(16'h0600, 2, 32'h1234_5678, 32'h0101_0101);
        drive_write(16'h0600, 2, 32'h1234_5678, 32'h0101_0101);

        repeat (3) @(posedge clk);
        check("exp_xfers_drained", exp_q.size(), 0);
        check("exp_rd_drained", exp_rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
